// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle processor control unit:
// state encodings, opcode constants, datapath select codes and the
// instruction-class record produced by the opcode decoder.
package multi_cycle_control_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EXEC   = 4'd6,
        ST_R_WB     = 4'd7,
        ST_I_EXEC   = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // One-hot instruction class; all zero means the opcode is not supported.
    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic beq;
        logic jump;
        logic addi;
        logic andi;
    } op_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Purely combinational opcode classifier and extender-mode select.
module mc_opcode_decode
    import multi_cycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output logic       ext_op
);

    // Map the opcode onto a one-hot class; andi is the only zero-extending op.
    always_comb begin
        op_class = '0;
        case (opcode)
            OP_RTYPE: op_class.rtype = 1'b1;
            OP_LW:    op_class.lw    = 1'b1;
            OP_SW:    op_class.sw    = 1'b1;
            OP_BEQ:   op_class.beq   = 1'b1;
            OP_J:     op_class.jump  = 1'b1;
            OP_ADDI:  op_class.addi  = 1'b1;
            OP_ANDI:  op_class.andi  = 1'b1;
            default:  op_class       = '0;
        endcase
        ext_op = (opcode != OP_ANDI);
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Moore control FSM for a multi-cycle MIPS-style datapath, with a
// retired-instruction counter and an illegal-opcode pulse.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        ext_op,
    output logic        illegal_op,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;
    logic        retire;
    op_class_t   op_class;

    // The zero flag qualifies pc_write_cond inside the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    mc_opcode_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class),
        .ext_op   (ext_op)
    );

    // Next-state, illegal pulse and retire strobe.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        retire    = 1'b0;
        case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (op_class.rtype)                  state_d = ST_R_EXEC;
                else if (op_class.lw || op_class.sw) state_d = ST_MEM_ADDR;
                else if (op_class.beq)               state_d = ST_BRANCH;
                else if (op_class.jump)              state_d = ST_JUMP;
                else if (op_class.addi || op_class.andi) state_d = ST_I_EXEC;
                else begin
                    state_d   = ST_FETCH;
                    illegal_d = 1'b1;
                end
            end
            ST_MEM_ADDR: state_d = op_class.lw ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end
            end
            ST_R_EXEC:   state_d = ST_R_WB;
            ST_I_EXEC:   state_d = ST_I_WB;
            ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            default:     state_d = ST_FETCH;
        endcase
        retired_d = retire ? retired_q + 32'd1 : retired_q;
    end

    // Moore control outputs; FETCH strobes also wait for memory and reset.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = mem_ready && rst_n;
                ir_write  = mem_ready && rst_n;
            end
            ST_DECODE:   alu_src_b = SRCB_IMM_SH2;
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = op_class.andi ? ALU_AND : ALU_ADD;
            end
            ST_I_WB:     reg_write = 1'b1;
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    // State, counter and pulse registers; reset abandons any instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    assign state      = state_q;
    assign retired    = retired_q;
    assign illegal_op = illegal_q;

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6: instruction bits [31:26], driven from the instruction register.
REQ-004 SHALL have port mem_ready, input, 1: memory access completes in the cycle this is high.
REQ-005 SHALL have port zero, input, 1: ALU zero flag.
REQ-006 SHALL have outputs pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a (1 each).
REQ-007 SHALL have outputs alu_src_b[1:0] (00 reg B, 01 const 4, 10 extended imm, 11 extended imm<<2), alu_op[1:0] (00 add, 01 sub, 10 funct, 11 and) and pc_source[1:0] (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have output ext_op, 1: selects the 16-to-32 extender mode; 1 = sign, 0 = zero.
REQ-009 SHALL have outputs illegal_op (1, one-cycle pulse), state[3:0] (debug) and retired[31:0] (retired-instruction count).

Function
REQ-010 SHALL implement a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
REQ-011 FETCH outputs SHALL be: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. pc_write and ir_write SHALL be 1 only while mem_ready=1. Stay in FETCH while mem_ready=0; otherwise go to DECODE.
REQ-012 DECODE outputs SHALL be: alu_src_a=0, alu_src_b=11, alu_op=00.
REQ-013 DECODE next state by opcode:
- 000000 -> R_EXEC
- 100011/101011 -> MEM_ADDR
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000/001100 -> I_EXEC
- any other opcode -> FETCH, with illegal_op=1 for that one cycle.
REQ-014 MEM_ADDR SHALL output alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEM_RD for lw and MEM_WR for sw.
REQ-015 MEM_RD SHALL output mem_read=1, iord=1; it holds until mem_ready=1, then goes to MEM_WB.
REQ-016 MEM_WB SHALL output reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-017 MEM_WR SHALL output mem_write=1, iord=1; it holds until mem_ready=1, then goes to FETCH.
REQ-018 R_EXEC SHALL output alu_src_a=1, alu_src_b=00, alu_op=10, then go to R_WB. R_WB SHALL output reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-019 I_EXEC SHALL output alu_src_a=1, alu_src_b=10, alu_op=00 for addi and 11 for andi. I_WB SHALL output reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-020 BRANCH SHALL output alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then go to FETCH. The PC updates only if zero=1; that qualification is performed in the datapath.
REQ-021 JUMP SHALL output pc_write=1, pc_source=10, then go to FETCH.
REQ-022 ext_op SHALL be a combinational function of opcode: 0 for 001100 (andi), 1 for every other opcode.
REQ-023 Any output not listed for a state SHALL be 0 in that state.
REQ-024 retired SHALL increment by 1 on each transition into FETCH from MEM_WB, MEM_WR (on mem_ready), R_WB, I_WB, BRANCH or JUMP. It SHALL NOT increment on an illegal-op return. It wraps from 0xFFFFFFFF to 0.
REQ-025 Instruction latencies in cycles, counted with mem_ready=1 throughout:
- lw: 5
- sw: 4
- R-type: 4
- addi/andi: 4
- beq: 3
- j: 3
Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR SHALL add one cycle.
REQ-026 state SHALL equal the encoding of the current state.

Reset
REQ-027 rst_n=0 SHALL immediately force state=FETCH, retired=0 and illegal_op=0, independent of clk.
REQ-028 While rst_n=0, pc_write, ir_write, mem_write and reg_write SHALL be 0. Reset asserted mid-instruction SHALL abandon that instruction.
REQ-029 After rst_n deasserts, the first fetch SHALL begin on the next rising edge with mem_ready honoured.

Structure
REQ-030 The shared package SHALL hold the state encodings, opcode constants (RTYPE, LW, SW, BEQ, J, ADDI, ANDI) and alu_op/alu_src_b/pc_source codes.
REQ-031 There SHALL be one sub-module, mc_opcode_decode: opcode in -> instruction-class one-hot and ext_op out, purely combinational.
REQ-032 The FSM, output decode and retired counter SHALL reside in multi_cycle_control.

Verification
REQ-033 Reset mid-R_EXEC -> state=0 (FETCH) and retired=0 without waiting for a clock edge; reg_write is never asserted.
REQ-034 lw (opcode 100011) with mem_ready=1 -> FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB across 5 cycles; reg_write=1 and mem_to_reg=1 in cycle 5; retired 0->1; ext_op=1.
REQ-035 sw with mem_ready low for 3 cycles in MEM_WR -> mem_write held high for 4 cycles; retired increments only after mem_ready=1.
REQ-036 beq with zero=1, then with zero=0 -> pc_write_cond=1 and pc_source=01 in BRANCH both times; 3 cycles each; retired +2.
REQ-037 andi (001100) -> ext_op=0 and alu_op=11 in I_EXEC; addi (001000) -> ext_op=1 and alu_op=00.
REQ-038 opcode 111111 -> DECODE->FETCH with a single illegal_op pulse; retired unchanged; no write strobes asserted.
